// File: rtl/ctrl_unit_mc.sv
// RISC-V main control unit: opcode/funct7 decode plus an iterative-multiply sequencer.
// Decode is combinational. A MUL stalls for MUL_LATENCY cycles and writes back in the following cycle.
// stall holds PC/IF/ID while the multiplier runs. flush squashes any pending writeback.
module ctrl_unit_mc #(
  parameter int MUL_LATENCY = 4,
  parameter bit ENABLE_MUL  = 1'b1
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       instr_valid,
  input  logic       flush,
  input  logic [6:0] opcode,
  input  logic [6:0] funct7,
  output logic [1:0] alu_op,
  output logic       alu_src,
  output logic       mem_2_reg,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       branch,
  output logic       jump,
  output logic       mult_sel,
  output logic       mult_start,
  output logic       stall,
  output logic       busy
);

  localparam int CW = $clog2(MUL_LATENCY + 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] F7_MUL    = 7'b0000001;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic [1:0] dec_alu_op;
  logic       dec_alu_src, dec_mem_2_reg, dec_reg_write;
  logic       dec_mem_read, dec_mem_write, dec_branch, dec_jump;
  logic       is_mul;

  assign is_mul = instr_valid && !flush && ENABLE_MUL &&
                  (opcode == OP_R) && (funct7 == F7_MUL);

  // Plain opcode decode; squashed or invalid slots decode to a no-op.
  always_comb begin
    dec_alu_op    = 2'b10;
    dec_alu_src   = 1'b0;
    dec_mem_2_reg = 1'b0;
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_branch    = 1'b0;
    dec_jump      = 1'b0;
    if (instr_valid && !flush) begin
      case (opcode)
        OP_R: begin
          dec_reg_write = 1'b1;
        end
        OP_I: begin
          dec_alu_src = 1'b1; dec_reg_write = 1'b1; dec_alu_op = 2'b00;
        end
        OP_BRANCH: begin
          dec_branch = 1'b1; dec_alu_op = 2'b01;
        end
        OP_JAL: begin
          dec_mem_2_reg = 1'b1; dec_reg_write = 1'b1; dec_jump = 1'b1; dec_alu_op = 2'b00;
        end
        OP_LOAD: begin
          dec_alu_src = 1'b1; dec_mem_2_reg = 1'b1; dec_reg_write = 1'b1;
          dec_mem_read = 1'b1; dec_alu_op = 2'b00;
        end
        OP_STORE: begin
          dec_alu_src = 1'b1; dec_mem_write = 1'b1; dec_alu_op = 2'b00;
        end
        default: ;
      endcase
    end
  end

  // Multiply sequencer: cnt counts the remaining BUSY cycles after the launch cycle.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mul) begin
            if (MUL_LATENCY == 1) begin
              state <= DONE;
            end else begin
              state <= BUSY;
              cnt   <= CW'(MUL_LATENCY - 1);
            end
          end
        end
        BUSY: begin
          if (flush) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CW'(1)) begin
            state <= DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          // The MUL is still held upstream here, so return to IDLE unconditionally.
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Output steering: IDLE passes the decode through; BUSY/DONE ignore the held instruction.
  always_comb begin
    alu_op     = dec_alu_op;
    alu_src    = dec_alu_src;
    mem_2_reg  = dec_mem_2_reg;
    reg_write  = dec_reg_write;
    mem_read   = dec_mem_read;
    mem_write  = dec_mem_write;
    branch     = dec_branch;
    jump       = dec_jump;
    mult_sel   = 1'b0;
    mult_start = 1'b0;
    stall      = 1'b0;
    if (state == IDLE) begin
      if (is_mul) begin
        mult_start = 1'b1;
        stall      = 1'b1;
        reg_write  = 1'b0;
      end
    end else begin
      alu_op    = 2'b10;
      alu_src   = 1'b0;
      mem_2_reg = 1'b0;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      branch    = 1'b0;
      jump      = 1'b0;
      if (state == BUSY) begin
        // A flush redirects the front end, so the hold is released that cycle.
        stall = !flush;
      end else if (!flush) begin
        reg_write = 1'b1;
        mult_sel  = 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ctrl_unit_mc.sv
// Directed bench for ctrl_unit_mc with three instances: latency 4, latency 1, multiply disabled.
// Inputs change 1 time unit after the rising edge and are checked 1 unit later.
// All instances share the same inputs; each one is checked against its own hand-derived table.
module tb_ctrl_unit_mc;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] F7_MUL = 7'b0000001;

  logic       clk;
  logic       arst_n;
  logic       instr_valid;
  logic       flush;
  logic [6:0] opcode;
  logic [6:0] funct7;

  // a: MUL_LATENCY=4, b: MUL_LATENCY=1, c: ENABLE_MUL=0
  logic [1:0] alu_op_a, alu_op_b, alu_op_c;
  logic alu_src_a, mem_2_reg_a, reg_write_a, mem_read_a, mem_write_a, branch_a, jump_a;
  logic mult_sel_a, mult_start_a, stall_a, busy_a;
  logic alu_src_b, mem_2_reg_b, reg_write_b, mem_read_b, mem_write_b, branch_b, jump_b;
  logic mult_sel_b, mult_start_b, stall_b, busy_b;
  logic alu_src_c, mem_2_reg_c, reg_write_c, mem_read_c, mem_write_c, branch_c, jump_c;
  logic mult_sel_c, mult_start_c, stall_c, busy_c;

  ctrl_unit_mc #(.MUL_LATENCY(4), .ENABLE_MUL(1'b1)) u_dut_a (
    .clk(clk), .arst_n(arst_n), .instr_valid(instr_valid), .flush(flush),
    .opcode(opcode), .funct7(funct7), .alu_op(alu_op_a), .alu_src(alu_src_a),
    .mem_2_reg(mem_2_reg_a), .reg_write(reg_write_a), .mem_read(mem_read_a),
    .mem_write(mem_write_a), .branch(branch_a), .jump(jump_a), .mult_sel(mult_sel_a),
    .mult_start(mult_start_a), .stall(stall_a), .busy(busy_a));

  ctrl_unit_mc #(.MUL_LATENCY(1), .ENABLE_MUL(1'b1)) u_dut_b (
    .clk(clk), .arst_n(arst_n), .instr_valid(instr_valid), .flush(flush),
    .opcode(opcode), .funct7(funct7), .alu_op(alu_op_b), .alu_src(alu_src_b),
    .mem_2_reg(mem_2_reg_b), .reg_write(reg_write_b), .mem_read(mem_read_b),
    .mem_write(mem_write_b), .branch(branch_b), .jump(jump_b), .mult_sel(mult_sel_b),
    .mult_start(mult_start_b), .stall(stall_b), .busy(busy_b));

  ctrl_unit_mc #(.MUL_LATENCY(4), .ENABLE_MUL(1'b0)) u_dut_c (
    .clk(clk), .arst_n(arst_n), .instr_valid(instr_valid), .flush(flush),
    .opcode(opcode), .funct7(funct7), .alu_op(alu_op_c), .alu_src(alu_src_c),
    .mem_2_reg(mem_2_reg_c), .reg_write(reg_write_c), .mem_read(mem_read_c),
    .mem_write(mem_write_c), .branch(branch_c), .jump(jump_c), .mult_sel(mult_sel_c),
    .mult_start(mult_start_c), .stall(stall_c), .busy(busy_c));

  // ctl = {alu_src, mem_2_reg, reg_write, mem_read, mem_write, branch, alu_op, jump}
  // st  = {mult_start, stall, mult_sel, busy}
  logic [8:0] ctl_a, ctl_b, ctl_c;
  logic [3:0] st_a, st_b, st_c;
  assign ctl_a = {alu_src_a, mem_2_reg_a, reg_write_a, mem_read_a, mem_write_a, branch_a, alu_op_a, jump_a};
  assign ctl_b = {alu_src_b, mem_2_reg_b, reg_write_b, mem_read_b, mem_write_b, branch_b, alu_op_b, jump_b};
  assign ctl_c = {alu_src_c, mem_2_reg_c, reg_write_c, mem_read_c, mem_write_c, branch_c, alu_op_c, jump_c};
  assign st_a  = {mult_start_a, stall_a, mult_sel_a, busy_a};
  assign st_b  = {mult_start_b, stall_b, mult_sel_b, busy_b};
  assign st_c  = {mult_start_c, stall_c, mult_sel_c, busy_c};

  localparam logic [8:0] CTL_NOP = 9'b000000100;
  localparam logic [8:0] CTL_R   = 9'b001000100;

  int n_tests = 0;
  int n_fail  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic f, input logic [6:0] op, input logic [6:0] f7);
    instr_valid = v;
    flush       = f;
    opcode      = op;
    funct7      = f7;
    #1;
  endtask

  // Reset is asserted and released mid-cycle, away from the clock edge.
  task automatic do_reset();
    instr_valid = 1'b0;
    flush       = 1'b0;
    arst_n      = 1'b0;
    #1;
    arst_n      = 1'b1;
  endtask

  logic [6:0] op_tab  [6] = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b0000011, 7'b0100011};
  logic [8:0] ctl_tab [6] = '{9'b001000100, 9'b101000000, 9'b000001010, 9'b011000001, 9'b111100000, 9'b100010000};

  // MUL held for k=0..4, ADD at k=5
  logic [3:0] st_a_tab  [6] = '{4'b1100, 4'b0101, 4'b0101, 4'b0101, 4'b0011, 4'b0000};
  logic [8:0] ctl_a_tab [6] = '{CTL_NOP, CTL_NOP, CTL_NOP, CTL_NOP, CTL_R, CTL_R};
  logic [3:0] st_b_tab  [6] = '{4'b1100, 4'b0011, 4'b1100, 4'b0011, 4'b1100, 4'b0011};
  logic [8:0] ctl_b_tab [6] = '{CTL_NOP, CTL_R, CTL_NOP, CTL_R, CTL_NOP, CTL_R};

  initial begin
    arst_n      = 1'b0;
    instr_valid = 1'b0;
    flush       = 1'b0;
    opcode      = 7'd0;
    funct7      = 7'd0;
    #2;
    chk("rst_st_a", 32'(st_a), 32'h0);
    chk("rst_st_b", 32'(st_b), 32'h0);
    chk("rst_ctl_a", 32'(ctl_a), 32'(CTL_NOP));
    #1;
    arst_n = 1'b1;

    // decode table
    for (int i = 0; i < 6; i++) begin
      nxt();
      set_in(1'b1, 1'b0, op_tab[i], 7'd0);
      chk($sformatf("dec_ctl_%0d", i), 32'(ctl_a), 32'(ctl_tab[i]));
      chk($sformatf("dec_st_%0d", i), 32'(st_a), 32'h0);
    end
    nxt(); set_in(1'b0, 1'b0, OP_R, 7'd0);
    chk("dec_invalid", 32'(ctl_a), 32'(CTL_NOP));
    nxt(); set_in(1'b1, 1'b1, 7'b0000011, 7'd0);
    chk("dec_flush", 32'(ctl_a), 32'(CTL_NOP));
    nxt(); set_in(1'b1, 1'b0, 7'b1110011, 7'd0);
    chk("dec_default", 32'(ctl_a), 32'(CTL_NOP));

    // MUL sequence on all three instances
    for (int k = 0; k < 6; k++) begin
      nxt();
      if (k < 5) set_in(1'b1, 1'b0, OP_R, F7_MUL);
      else       set_in(1'b1, 1'b0, OP_R, 7'd0);
      chk($sformatf("mul4_st_%0d", k), 32'(st_a), 32'(st_a_tab[k]));
      chk($sformatf("mul4_ctl_%0d", k), 32'(ctl_a), 32'(ctl_a_tab[k]));
      chk($sformatf("mul1_st_%0d", k), 32'(st_b), 32'(st_b_tab[k]));
      chk($sformatf("mul1_ctl_%0d", k), 32'(ctl_b), 32'(ctl_b_tab[k]));
      chk($sformatf("nomul_st_%0d", k), 32'(st_c), 32'h0);
      chk($sformatf("nomul_ctl_%0d", k), 32'(ctl_c), 32'(CTL_R));
    end

    // flush during BUSY (a) and during DONE (b)
    do_reset();
    nxt(); set_in(1'b1, 1'b0, OP_R, F7_MUL);
    chk("fl_launch_a", 32'(st_a), 32'b1100);
    nxt(); set_in(1'b1, 1'b1, OP_R, F7_MUL);
    chk("fl_busy_rw_msel_a", 32'({reg_write_a, mult_sel_a}), 32'h0);
    chk("fl_done_rw_msel_b", 32'({reg_write_b, mult_sel_b}), 32'h0);
    for (int k = 0; k < 4; k++) begin
      nxt(); set_in(1'b0, 1'b0, OP_R, F7_MUL);
      chk($sformatf("fl_after_st_a_%0d", k), 32'(st_a), 32'h0);
      chk($sformatf("fl_after_ctl_a_%0d", k), 32'(ctl_a), 32'(CTL_NOP));
      chk($sformatf("fl_after_st_b_%0d", k), 32'(st_b), 32'h0);
    end

    // flush in IDLE on a MUL never launches
    nxt(); set_in(1'b1, 1'b1, OP_R, F7_MUL);
    chk("fl_idle_st_a", 32'(st_a), 32'h0);
    chk("fl_idle_ctl_a", 32'(ctl_a), 32'(CTL_NOP));
    nxt(); set_in(1'b0, 1'b0, OP_R, 7'd0);
    chk("fl_idle_next_busy", 32'(busy_a), 32'h0);

    // async reset in the middle of BUSY
    nxt(); set_in(1'b1, 1'b0, OP_R, F7_MUL);
    chk("ar_launch_a", 32'(st_a), 32'b1100);
    nxt(); set_in(1'b1, 1'b0, OP_R, F7_MUL);
    chk("ar_busy_a", 32'(st_a), 32'b0101);
    #2;
    arst_n      = 1'b0;
    instr_valid = 1'b0;
    #1;
    chk("ar_abort_st_a", 32'(st_a), 32'h0);
    chk("ar_abort_rw_a", 32'(reg_write_a), 32'h0);
    #1;
    arst_n = 1'b1;
    nxt(); set_in(1'b1, 1'b0, OP_R, 7'd0);
    chk("ar_add_ctl_a", 32'(ctl_a), 32'(CTL_R));
    chk("ar_add_st_a", 32'(st_a), 32'h0);
    nxt(); set_in(1'b0, 1'b0, OP_R, 7'd0);
    chk("ar_quiet_st_a", 32'(st_a), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_unit_mc.md
Name: ctrl_unit_mc

Overview:
- Next-generation RISC-V main control unit with multi-cycle multiply support.
- Decodes opcode/funct7 into datapath control signals, as the single-cycle control unit does.
- Recognises MUL (R-type, funct7=0000001) and sequences an iterative multiplier with a counter FSM, stalling the pipeline for a parametrised latency.
- Sits in the decode stage between the instruction register and the datapath/hazard logic.

Parameters:
MUL_LATENCY, 4, multiplier cycles (>=1); total stall cycles per MUL.
ENABLE_MUL, 1, 0 = MUL decoded as plain R-type, FSM never leaves IDLE.

Ports:
clk  input  1  system clock, rising edge.
arst_n  input  1  asynchronous active-low reset.
instr_valid  input  1  decode-stage instruction is valid.
flush  input  1  squash the current instruction (branch taken/exception).
opcode  input  7  instr[6:0].
funct7  input  7  instr[31:25].
alu_op  output  2  00 add, 01 sub, 10 R-type.
alu_src  output  1  ALU B operand = immediate.
mem_2_reg  output  1  writeback selects memory/link path.
reg_write  output  1  register-file write enable.
mem_read  output  1  data-memory read.
mem_write  output  1  data-memory write.
branch  output  1  conditional branch.
jump  output  1  JAL.
mult_sel  output  1  writeback selects multiplier result.
mult_start  output  1  one-cycle multiplier launch pulse.
stall  output  1  hold PC/IF/ID registers.
busy  output  1  FSM not IDLE.

Behaviour:
- Decode is combinational. All control outputs are 0 when instr_valid=0 or flush=1. Exception: alu_op, which is 10 in those cases and in the default case.
- Decode table, as (alu_src, mem_2_reg, reg_write, mem_read, mem_write, branch, alu_op, jump):
  - 0110011: 0,0,1,0,0,0,10,0
  - 0010011: 1,0,1,0,0,0,00,0
  - 1100011: 0,0,0,0,0,1,01,0
  - 1101111: 0,1,1,0,0,0,00,1
  - 0000011: 1,1,1,1,0,0,00,0
  - 0100011: 1,0,0,0,1,0,00,0
  - default: all 0, alu_op=10.
- is_mul = instr_valid & ~flush & ENABLE_MUL & opcode==0110011 & funct7==0000001.
- FSM states: IDLE, BUSY, DONE. Counter width is clog2(MUL_LATENCY+1).
- Reset (async, arst_n=0): state=IDLE, cnt=0. mult_start, stall, busy and mult_sel are then 0.
- IDLE with is_mul:
  - mult_start=1, stall=1, reg_write forced 0.
  - Next state: DONE if MUL_LATENCY==1, else BUSY with cnt=MUL_LATENCY-1.
- BUSY:
  - stall=1, reg_write=0, mult_start=0.
  - If cnt==1, next state DONE; else cnt decrements.
  - instr_valid and opcode are ignored, since the upstream stage holds the instruction.
- DONE:
  - stall=0, mult_sel=1, reg_write=1, alu_op=10.
  - Next state is always IDLE; the held MUL must not relaunch.
- Timing: a MUL first seen at cycle T stalls cycles T..T+MUL_LATENCY-1 and writes back at T+MUL_LATENCY.
- mult_sel=0 and stall=0 in IDLE for every non-MUL instruction.
- flush while BUSY or DONE: next state IDLE, cnt=0, and reg_write/mult_sel are 0 that cycle. flush has priority over DONE.
- flush in IDLE on a MUL: no mult_start, no stall.
- Reset mid-operation aborts immediately to IDLE with no writeback.
- busy=1 in BUSY and DONE.

Test Plan:
- Reset then decode each of the six opcodes with instr_valid=1 -> outputs exactly match the decode table; stall=0, mult_start=0.
- MUL (opcode 0110011, funct7 0000001) at T=10, MUL_LATENCY=4 -> mult_start=1 at T=10 only; stall=1 at T=10..13; reg_write=0 at T=10..13; DONE at T=14 with reg_write=1, mult_sel=1; IDLE at T=15.
- MUL_LATENCY=1 -> stall for one cycle only (T), DONE at T+1; back-to-back MULs -> second mult_start at T+2.
- flush asserted during BUSY (second stall cycle) -> next cycle IDLE, stall=0, no DONE, reg_write never 1.
- arst_n pulsed low during BUSY -> immediate IDLE; stall/busy/mult_start=0; following ADD decodes normally.
- ENABLE_MUL=0, MUL opcode -> plain R-type outputs (reg_write=1, alu_op=10), stall=0, mult_start never asserted.
